// File: rtl/shared_ram_pkg.sv
// Shared constants and helpers for the shared-RAM arbiter and other round-robin arbiters.
package shared_ram_pkg;

   localparam int WORD_BYTES = 4;
   localparam int DATA_WIDTH = 32;
   localparam int MAX_REQ    = 8;

   function automatic int idx_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Rotates the low n bits of v left by amt (0 < amt <= n); bits at and above n stay zero.
   function automatic logic [MAX_REQ-1:0] rotl(input logic [MAX_REQ-1:0] v,
                                               input int amt,
                                               input int n);
      logic [MAX_REQ-1:0] r;
      int j;
      r = '0;
      for (int k = 0; k < MAX_REQ; k++) begin
         if (k < n) begin
            j = k + amt;
            if (j >= n) j = j - n;
            r[j[2:0]] = v[k];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
// Zero latency; no state, so no backpressure of its own.
module rr_priority_pick
   import shared_ram_pkg::*;
#(
   parameter int N = 2
) (
   input  logic [N-1:0]            req,
   input  logic [idx_width(N)-1:0] ptr,
   output logic [N-1:0]            gnt,
   output logic [idx_width(N)-1:0] idx,
   output logic                    found
);

   localparam int IW = idx_width(N);

   logic [MAX_REQ-1:0] req_ext;
   logic [MAX_REQ-1:0] rot;
   int                 first;
   int                 sum;

   always_comb begin
      req_ext        = '0;
      req_ext[N-1:0] = req;
      // Rotating left by N-ptr moves requester ptr down to bit 0.
      rot   = rotl(req_ext, N - int'(ptr), N);
      first = 0;
      found = 1'b0;
      for (int i = MAX_REQ - 1; i >= 0; i--) begin
         if (rot[i]) begin
            first = i;
            found = 1'b1;
         end
      end
      sum = first + int'(ptr);
      if (sum >= N) sum = sum - N;
      idx = IW'(sum);
      gnt = '0;
      if (found) gnt[idx] = 1'b1;
   end

endmodule

// File: rtl/shared_ram_arbiter.sv
// Round-robin arbiter of NUM_REQ requesters onto one RAM port, with lock for RMW sequences.
// Grant is same-cycle; response one cycle after acceptance; a locked idle owner stalls everyone else.
module shared_ram_arbiter
   import shared_ram_pkg::*;
#(
   parameter int ADDR_WIDTH = 6,
   parameter int NUM_REQ    = 2
) (
   input  logic                             clk,
   input  logic                             resetn,
   input  logic [NUM_REQ-1:0]               req_valid,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
   input  logic [NUM_REQ*WORD_BYTES-1:0]    req_wstrb,
   input  logic [NUM_REQ-1:0]               req_lock,
   output logic [NUM_REQ-1:0]               req_ready,
   output logic [NUM_REQ-1:0]               rsp_valid,
   output logic [DATA_WIDTH-1:0]            rsp_rdata,
   output logic [ADDR_WIDTH-1:0]            ram_addr,
   output logic [DATA_WIDTH-1:0]            ram_wdata,
   output logic [WORD_BYTES-1:0]            ram_we,
   input  logic [DATA_WIDTH-1:0]            ram_q
);

   localparam int IW = idx_width(NUM_REQ);

   logic [IW-1:0]         rr_ptr;
   logic                  lock_vld;
   logic [IW-1:0]         lock_id;
   logic                  rsp_pend;
   logic [IW-1:0]         rsp_id;
   logic [ADDR_WIDTH-1:0] last_addr;
   logic [DATA_WIDTH-1:0] last_wdata;

   logic [NUM_REQ-1:0]    pick_gnt;
   logic [IW-1:0]         pick_idx;
   logic                  pick_found;
   logic                  gnt_vld;
   logic [IW-1:0]         gnt_idx;

   rr_priority_pick #(.N(NUM_REQ)) u_pick (
      .req   (req_valid),
      .ptr   (rr_ptr),
      .gnt   (pick_gnt),
      .idx   (pick_idx),
      .found (pick_found)
   );

   always_comb begin
      gnt_vld   = 1'b0;
      gnt_idx   = '0;
      req_ready = '0;
      if (!resetn) begin
         gnt_vld = 1'b0;
      end else if (lock_vld && req_valid[lock_id]) begin
         gnt_vld            = 1'b1;
         gnt_idx            = lock_id;
         req_ready[lock_id] = 1'b1;
      end else if (!(lock_vld && req_lock[lock_id]) && pick_found) begin
         gnt_vld   = 1'b1;
         gnt_idx   = pick_idx;
         req_ready = pick_gnt;
      end
   end

   // Idle cycles keep the last address/data on the port; only ram_we drops.
   always_comb begin
      ram_addr  = resetn ? last_addr : '0;
      ram_wdata = last_wdata;
      ram_we    = '0;
      if (gnt_vld) begin
         ram_addr  = req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
         ram_wdata = req_wdata[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
         ram_we    = req_wstrb[int'(gnt_idx)*WORD_BYTES +: WORD_BYTES];
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         rr_ptr     <= '0;
         lock_vld   <= 1'b0;
         lock_id    <= '0;
         rsp_pend   <= 1'b0;
         rsp_id     <= '0;
         last_addr  <= '0;
         last_wdata <= '0;
      end else begin
         rsp_pend <= gnt_vld;
         if (gnt_vld) begin
            rsp_id     <= gnt_idx;
            rr_ptr     <= (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
            last_addr  <= ram_addr;
            last_wdata <= ram_wdata;
            lock_vld   <= req_lock[gnt_idx];
            lock_id    <= gnt_idx;
         end else if (lock_vld && !req_valid[lock_id] && !req_lock[lock_id]) begin
            lock_vld <= 1'b0;
         end
      end
   end

   always_comb begin
      rsp_valid = '0;
      if (rsp_pend && resetn) rsp_valid[rsp_id] = 1'b1;
      rsp_rdata = ram_q;
   end

endmodule

// File: tb/tb_shared_ram_arbiter.sv
// Directed and random stimulus for shared_ram_arbiter against a behavioural model of the arbitration rules.
module tb_shared_ram_arbiter;

   localparam int AW = 6;
   localparam int N  = 2;

   logic            clk = 1'b0;
   logic            resetn;
   logic [N-1:0]    req_valid;
   logic [N*AW-1:0] req_addr;
   logic [N*32-1:0] req_wdata;
   logic [N*4-1:0]  req_wstrb;
   logic [N-1:0]    req_lock;
   logic [N-1:0]    req_ready;
   logic [N-1:0]    rsp_valid;
   logic [31:0]     rsp_rdata;
   logic [AW-1:0]   ram_addr;
   logic [31:0]     ram_wdata;
   logic [3:0]      ram_we;
   logic [31:0]     ram_q;

   always #5 clk = ~clk;

   shared_ram_arbiter #(.ADDR_WIDTH(AW), .NUM_REQ(N)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .req_valid (req_valid),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_wstrb (req_wstrb),
      .req_lock  (req_lock),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_we    (ram_we),
      .ram_q     (ram_q)
   );

   // Byte-lane RAM with registered read (old data on same-cycle write).
   logic [31:0] ram_mem [0:63];
   always @(posedge clk) begin
      for (int b = 0; b < 4; b++)
         if (ram_we[b]) ram_mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
      ram_q <= ram_mem[ram_addr];
   end

   // Reference model state
   int          m_ptr;
   int          m_owner;
   bit          m_pend;
   bit          m_pend_read;
   int          m_pend_id;
   logic [31:0] m_pend_data;
   logic [31:0] m_mem [0:63];
   bit          m_addr_known;
   logic [AW-1:0] m_last_addr;
   int          grants[$];

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [AW-1:0] f_addr(input int i);
      return req_addr[i*AW +: AW];
   endfunction
   function automatic logic [31:0] f_wdata(input int i);
      return req_wdata[i*32 +: 32];
   endfunction
   function automatic logic [3:0] f_wstrb(input int i);
      return req_wstrb[i*4 +: 4];
   endfunction

   task automatic set_req(input int i, input bit v, input logic [AW-1:0] a,
                          input logic [31:0] d, input logic [3:0] s, input bit l);
      req_valid[i]        = v;
      req_addr[i*AW +: AW] = a;
      req_wdata[i*32 +: 32] = d;
      req_wstrb[i*4 +: 4] = s;
      req_lock[i]         = l;
   endtask

   task automatic idle_all();
      for (int i = 0; i < N; i++) set_req(i, 1'b0, '0, '0, '0, 1'b0);
   endtask

   // One clock cycle: check this cycle's outputs at the falling edge, then advance the model.
   task automatic step();
      int          win;
      int          j;
      logic [31:0] exp_ready;
      logic [31:0] exp_rsp;
      logic [31:0] word;
      @(negedge clk);
      win = -1;
      if (resetn) begin
         if (m_owner >= 0 && req_valid[m_owner]) win = m_owner;
         else if (m_owner >= 0 && req_lock[m_owner]) win = -1;
         else begin
            for (int k = 0; k < N; k++) begin
               j = (m_ptr + k) % N;
               if (win < 0 && req_valid[j]) win = j;
            end
         end
      end
      exp_ready = (win >= 0) ? (32'd1 << win) : 32'd0;
      check("req_ready", 32'(req_ready), exp_ready);
      check("ram_we", 32'(ram_we), (win >= 0) ? 32'(f_wstrb(win)) : 32'd0);
      if (!resetn) check("ram_addr_rst", 32'(ram_addr), 32'd0);
      else if (win >= 0) begin
         check("ram_addr", 32'(ram_addr), 32'(f_addr(win)));
         check("ram_wdata", ram_wdata, f_wdata(win));
      end else if (m_addr_known) check("ram_addr_hold", 32'(ram_addr), 32'(m_last_addr));
      exp_rsp = (resetn && m_pend) ? (32'd1 << m_pend_id) : 32'd0;
      check("rsp_valid", 32'(rsp_valid), exp_rsp);
      if (exp_rsp != 0 && m_pend_read) check("rsp_rdata", rsp_rdata, m_pend_data);

      grants.push_back(win);
      if (!resetn) begin
         m_ptr        = 0;
         m_owner      = -1;
         m_pend       = 1'b0;
         m_addr_known = 1'b0;
      end else begin
         m_pend = (win >= 0);
         if (win >= 0) begin
            m_pend_id   = win;
            m_pend_read = (f_wstrb(win) == 4'h0);
            word        = m_mem[f_addr(win)];
            m_pend_data = word;
            for (int b = 0; b < 4; b++)
               if (f_wstrb(win)[b]) word[b*8 +: 8] = f_wdata(win)[b*8 +: 8];
            m_mem[f_addr(win)] = word;
            m_ptr        = (win + 1) % N;
            m_owner      = req_lock[win] ? win : -1;
            m_last_addr  = f_addr(win);
            m_addr_known = 1'b1;
         end else if (m_owner >= 0 && !req_valid[m_owner] && !req_lock[m_owner]) begin
            m_owner = -1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int g0;
      int alt_exp[6];
      int lock_exp[8];
      for (int a = 0; a < 64; a++) begin
         ram_mem[a] = 32'h0;
         m_mem[a]   = 32'h0;
      end
      m_ptr = 0; m_owner = -1; m_pend = 1'b0; m_pend_read = 1'b0; m_pend_id = 0;
      m_pend_data = '0; m_addr_known = 1'b0; m_last_addr = '0;
      resetn = 1'b0;
      idle_all();

      // Reset, then idle
      step(); step();
      resetn = 1'b1;
      for (int c = 0; c < 10; c++) step();

      // Full-word write then read-back
      set_req(0, 1'b1, 6'd5, 32'hDEADBEEF, 4'hF, 1'b0);
      step();
      set_req(0, 1'b1, 6'd5, 32'h0, 4'h0, 1'b0);
      step();
      idle_all();
      check("rd5_valid", 32'(rsp_valid), 32'h1);
      check("rd5_data", rsp_rdata, 32'hDEADBEEF);
      step();

      // Byte-lane write
      set_req(0, 1'b1, 6'd3, 32'h11223344, 4'hF, 1'b0);
      step();
      set_req(0, 1'b1, 6'd3, 32'h0000AA00, 4'h2, 1'b0);
      step();
      set_req(0, 1'b1, 6'd3, 32'h0, 4'h0, 1'b0);
      step();
      idle_all();
      check("rd3_data", rsp_rdata, 32'h1122AA44);
      step();

      // Move priority to requester 0, then both request continuously
      set_req(1, 1'b1, 6'd7, 32'h0, 4'h0, 1'b0);
      step();
      set_req(0, 1'b1, 6'd3, 32'h0, 4'h0, 1'b0);
      set_req(1, 1'b1, 6'd5, 32'h0, 4'h0, 1'b0);
      g0 = grants.size();
      alt_exp = '{0, 1, 0, 1, 0, 1};
      for (int c = 0; c < 6; c++) step();
      for (int c = 0; c < 6; c++) check("alt_grant", 32'(grants[g0 + c]), 32'(alt_exp[c]));
      idle_all();
      step();

      // Lock held by requester 1 for three accesses, then an idle-lock stall
      g0 = grants.size();
      lock_exp = '{1, 1, 1, 0, 1, -1, -1, 0};
      set_req(1, 1'b1, 6'd10, 32'h00000001, 4'hF, 1'b1);
      step();
      set_req(0, 1'b1, 6'd5, 32'h0, 4'h0, 1'b0);
      set_req(1, 1'b1, 6'd10, 32'h0, 4'h0, 1'b1);
      step();
      set_req(1, 1'b1, 6'd10, 32'h00000002, 4'h1, 1'b0);
      step();
      set_req(1, 1'b0, 6'd10, 32'h0, 4'h0, 1'b0);
      step();
      set_req(1, 1'b1, 6'd11, 32'h0, 4'h0, 1'b1);
      step();
      set_req(1, 1'b0, 6'd11, 32'h0, 4'h0, 1'b1);
      step(); step();
      set_req(1, 1'b0, 6'd11, 32'h0, 4'h0, 1'b0);
      step();
      for (int c = 0; c < 8; c++) check("lock_grant", 32'(grants[g0 + c]), 32'(lock_exp[c]));
      idle_all();
      step();

      // Reset the cycle after a read accept
      set_req(0, 1'b1, 6'd10, 32'h0, 4'h0, 1'b0);
      step();
      resetn = 1'b0;
      set_req(0, 1'b1, 6'd20, 32'h00000BAD, 4'hF, 1'b1);
      set_req(1, 1'b1, 6'd20, 32'h00000BAD, 4'hF, 1'b1);
      step();
      resetn = 1'b1;
      set_req(0, 1'b1, 6'd20, 32'h0, 4'h0, 1'b0);
      set_req(1, 1'b1, 6'd20, 32'h0, 4'h0, 1'b0);
      step();
      check("post_rst_grant", 32'(grants[grants.size() - 1]), 32'd0);
      check("post_rst_rsp", 32'(rsp_valid), 32'h1);
      check("post_rst_data", rsp_rdata, 32'h0);
      idle_all();
      step();

      // Random traffic
      for (int c = 0; c < 400; c++) begin
         resetn = ($urandom_range(0, 49) != 0);
         for (int i = 0; i < N; i++)
            set_req(i, $urandom_range(0, 1) == 1, AW'($urandom_range(0, 63)), $urandom,
                    ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0,
                    $urandom_range(0, 3) == 0);
         step();
      end
      resetn = 1'b1;
      idle_all();
      step(); step();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/shared_ram_arbiter.md
Name: shared_ram_arbiter

Overview:
- Arbitrates NUM_REQ requesters onto one port (A or B) of the byte-lane shared RAM, e.g. core data bus plus loader/debug master on port A while instruction fetch owns port B.
- Round-robin grant, one access per cycle, optional lock for read-modify-write sequences.
- Read data is returned one cycle after the grant, with a per-requester response strobe.

Parameters:
- ADDR_WIDTH, 6, word address width; matches the RAM.
- NUM_REQ, 2, number of requesters, 2..8.

Ports:
- clk  input  1  single system clock, rising edge.
- resetn  input  1  synchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester access request.
- req_addr  input  NUM_REQ*ADDR_WIDTH  word address, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  input  NUM_REQ*32  write data, requester i at [i*32 +: 32].
- req_wstrb  input  NUM_REQ*4  byte write enables; all-zero means read.
- req_lock  input  NUM_REQ  holds the grant on this requester after its current grant.
- req_ready  output  NUM_REQ  one-hot grant; the access is accepted in the cycle where req_valid and req_ready are both high.
- rsp_valid  output  NUM_REQ  one-hot; high the cycle after acceptance, for reads and for writes.
- rsp_rdata  output  32  RAM read data, meaningful only when a read response is valid.
- ram_addr  output  ADDR_WIDTH  to RAM addr port.
- ram_wdata  output  32  to RAM data port.
- ram_we  output  4  to RAM we port.
- ram_q  input  32  from RAM q port.

Behaviour:
- Reset (resetn low at a clk edge):
  - rsp_valid = 0; rr pointer = 0, so requester 0 has highest priority; lock owner cleared.
  - req_ready, ram_we and ram_addr are combinational. While resetn is low they are forced to req_ready = 0, ram_we = 0, ram_addr = 0.
- Grant, combinational in the same cycle:
  - If the lock owner is set and that requester asserts req_valid, it is granted.
  - Otherwise, the first valid requester searching from rr pointer upward, wrapping modulo NUM_REQ.
  - No valid request: req_ready = 0, ram_we = 0, ram_addr/ram_wdata hold the last granted values (no spurious writes).
- RAM drive: ram_addr, ram_wdata and ram_we are muxed from the granted requester. ram_we = req_wstrb of the winner; otherwise 0.
- Pointer update on acceptance: rr pointer <= winner + 1, wrapping NUM_REQ-1 -> 0.
- Lock rules:
  - Accepted with req_lock = 1: lock owner <= winner.
  - Owner accepted with req_lock = 0: lock cleared.
  - Owner deasserts both req_valid and req_lock: lock cleared next edge.
  - While locked and the owner is idle with lock still high: no other requester is granted. Stall is by design; the owner must bound its lock.
- Response:
  - Registered rsp_id/rsp_pend is set on acceptance. The next cycle rsp_valid[rsp_id] = 1 and rsp_rdata = ram_q, so total read latency is 1 cycle.
  - Back-to-back accepts give one rsp_valid per cycle, pipelined, with no bubbles.
  - Write responses pass ram_q through; requesters ignore rdata on writes.
- Simultaneous events:
  - A lock request and a competing request in the same cycle: normal round-robin decides.
  - A requester dropping req_valid without req_ready: no effect, no state change.
- Reset mid-operation: a pending response is dropped (rsp_valid = 0 the next cycle) and the lock is released. A write accepted in the reset cycle does not occur, because ram_we is forced to 0.
- Requests are level-held; the arbiter never buffers more than the one in-flight response.

Decomposition:
- Package shared_ram_pkg:
  - WORD_BYTES = 4, DATA_WIDTH = 32.
  - Function for the width of a one-hot-to-index conversion.
  - Function for a rotate-left of a NUM_REQ vector, used by round-robin.
- One sub-module, rr_priority_pick. Inputs: request vector and pointer. Outputs: one-hot grant and index. Purely combinational and reused by other arbiters.
- The top level holds the pointer, lock, response registers and RAM mux.

Test Plan:
- Reset then idle, all req_valid = 0 -> req_ready = 0, ram_we = 0, rsp_valid = 0 for 10 cycles.
- Requester 0 writes addr 5, wdata 0xDEADBEEF, wstrb 0xF. Next cycle it reads addr 5 -> rsp_valid[0] is high the cycle after the read grant, rsp_rdata = 0xDEADBEEF.
- Byte-lane write: addr 3 holds 0x11223344; write wstrb 0x2, wdata 0x0000AA00; read addr 3 -> 0x1122AA44.
- Both requesters hold req_valid for 6 cycles -> grants alternate 0,1,0,1,0,1 and rsp_valid follows one cycle later, one per cycle.
- Requester 1 accepted with lock = 1 for 3 accesses while requester 0 is also requesting -> grants 1,1,1. After requester 1 releases, requester 0 is granted on the next cycle.
- Reset asserted the cycle after a read accept -> no rsp_valid, no ram_we. After release the pointer = 0, so requester 0 wins a simultaneous request.
